mem_arbiter: RTL and testbench

Parametrised N-to-1 arbiter for the core memory bus: merges `N_PORTS` upstream masters (fetch, load/store, debug) onto one downstream memory slave using the same request (`m_*`) / response (`s_*`) valid-ready handshake. Adds round-robin arbitration, configurable address/data width, and up to `MAX_OUTSTANDING` in-flight loads whose responses are routed back, in order, to the issuing port.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_id_fifo.sv | 65 ++++++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and helpers for the core memory bus arbiter.
//   MEM_ADDR_W / MEM_DATA_W : default address and data widths of the bus
//   port_idx_width()        : bits needed to name one upstream port (at least 1)
package mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  // $clog2 collapses to 0 for a single port, which would make a zero-width index.
  function automatic int port_idx_width(input int n_ports);
    return (n_ports > 2) ? $clog2(n_ports) : 1;
  endfunction

endpackage

// File: rtl/mem_id_fifo.sv
// Small synchronous FIFO that remembers which upstream port issued each
// in-flight load, so responses can be steered back in issue order.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : enqueue din (ignored when full)
//   pop        : dequeue the front entry (ignored when empty)
//   front      : oldest entry
//   empty/full : occupancy flags
//   count      : number of stored entries
module mem_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             front,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly at DEPTH, so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign front   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-to-1 round-robin arbiter for the core memory bus.
//   clk, rst_n           : clock, asynchronous active-low reset
//   up_m_* (per port)    : upstream requests (address/data/write/valid in, ready out)
//   up_s_data/valid/ready: response data broadcast, per-port response valid/accept
//   dn_m_*               : registered downstream request
//   dn_s_*               : downstream response (passed straight through to the issuer)
// Loads are tracked in an ID FIFO of MAX_OUTSTANDING entries; stores get no response.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int N_PORTS         = 2,
  parameter int ADDR_W          = MEM_ADDR_W,
  parameter int DATA_W          = MEM_DATA_W,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS*ADDR_W-1:0]   up_m_address,
  input  logic [N_PORTS*DATA_W-1:0]   up_m_data,
  input  logic [N_PORTS-1:0]          up_m_write,
  input  logic [N_PORTS-1:0]          up_m_valid,
  output logic [N_PORTS-1:0]          up_m_ready,
  output logic [DATA_W-1:0]           up_s_data,
  output logic [N_PORTS-1:0]          up_s_valid,
  input  logic [N_PORTS-1:0]          up_s_ready,
  output logic [ADDR_W-1:0]           dn_m_address,
  output logic [DATA_W-1:0]           dn_m_data,
  output logic                        dn_m_write,
  output logic                        dn_m_valid,
  input  logic                        dn_m_ready,
  input  logic [DATA_W-1:0]           dn_s_data,
  input  logic                        dn_s_valid,
  output logic                        dn_s_ready
);

  localparam int IDX_W = port_idx_width(N_PORTS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0]   rr;
  logic [IDX_W-1:0]   win;
  logic               any_elig;
  logic               slot_open;
  logic               grant;
  logic [N_PORTS-1:0] eligible;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_write;
  logic               fifo_push;
  logic               fifo_pop;
  logic [IDX_W-1:0]   fifo_front;
  logic               fifo_empty;
  logic               fifo_full;
  logic [CNT_W-1:0]   fifo_count;

  // Port index k places after the round-robin pointer, wrapping at N_PORTS.
  function automatic int rot_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return (s >= N_PORTS) ? s - N_PORTS : s;
  endfunction

  assign slot_open = !dn_m_valid || dn_m_ready;
  // Loads wait while the ID FIFO is full; a same-cycle pop does not free a slot.
  assign eligible  = up_m_valid & (up_m_write | {N_PORTS{!fifo_full}});
  assign grant     = rst_n && slot_open && any_elig;
  assign fifo_push = grant && !sel_write;
  assign fifo_pop  = dn_s_valid && dn_s_ready;
  assign up_s_data = dn_s_data;

  // Rotated priority pick: first eligible port at or after rr.
  always_comb begin
    any_elig = 1'b0;
    win      = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (!any_elig && eligible[rot_idx(rr, k)]) begin
        any_elig = 1'b1;
        win      = IDX_W'(rot_idx(rr, k));
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_data  = '0;
    sel_write = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (win == IDX_W'(i)) begin
        sel_addr  = up_m_address[i*ADDR_W +: ADDR_W];
        sel_data  = up_m_data[i*DATA_W +: DATA_W];
        sel_write = up_m_write[i];
      end
    end
  end

  // Per-port handshakes: request grant to the winner, response to the FIFO head.
  always_comb begin
    up_m_ready = '0;
    up_s_valid = '0;
    dn_s_ready = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      up_m_ready[i] = grant && (win == IDX_W'(i));
      if (fifo_front == IDX_W'(i)) begin
        up_s_valid[i] = dn_s_valid && !fifo_empty;
        dn_s_ready    = !fifo_empty && up_s_ready[i];
      end
    end
  end

  // Downstream request register; contents only move when the slot is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_m_valid   <= 1'b0;
      dn_m_address <= '0;
      dn_m_data    <= '0;
      dn_m_write   <= 1'b0;
      rr           <= '0;
    end else if (slot_open) begin
      if (any_elig) begin
        dn_m_valid   <= 1'b1;
        dn_m_address <= sel_addr;
        dn_m_data    <= sel_data;
        dn_m_write   <= sel_write;
        rr           <= (win == IDX_W'(N_PORTS - 1)) ? '0 : win + 1'b1;
      end else begin
        dn_m_valid   <= 1'b0;
      end
    end
  end

  mem_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (win),
    .pop   (fifo_pop),
    .front (fifo_front),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter (3 ports, 2 outstanding loads).
// Each row drives one cycle of inputs at the falling edge and compares the
// outputs shortly after, before the next rising edge updates state.
module tb_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;
  localparam logic [DW-1:0] P0D = 32'h0000_00D0;
  localparam logic [DW-1:0] P1D = 32'h0000_00D1;
  localparam logic [DW-1:0] P2D = 32'h0000_00D2;

  logic              clk;
  logic              rst_n;
  logic [N*AW-1:0]   up_m_address;
  logic [N*DW-1:0]   up_m_data;
  logic [N-1:0]      up_m_write;
  logic [N-1:0]      up_m_valid;
  logic [N-1:0]      up_m_ready;
  logic [DW-1:0]     up_s_data;
  logic [N-1:0]      up_s_valid;
  logic [N-1:0]      up_s_ready;
  logic [AW-1:0]     dn_m_address;
  logic [DW-1:0]     dn_m_data;
  logic              dn_m_write;
  logic              dn_m_valid;
  logic              dn_m_ready;
  logic [DW-1:0]     dn_s_data;
  logic              dn_s_valid;
  logic              dn_s_ready;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(
    .N_PORTS (N), .ADDR_W (AW), .DATA_W (DW), .MAX_OUTSTANDING (MO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .up_m_address (up_m_address),
    .up_m_data    (up_m_data),
    .up_m_write   (up_m_write),
    .up_m_valid   (up_m_valid),
    .up_m_ready   (up_m_ready),
    .up_s_data    (up_s_data),
    .up_s_valid   (up_s_valid),
    .up_s_ready   (up_s_ready),
    .dn_m_address (dn_m_address),
    .dn_m_data    (dn_m_data),
    .dn_m_write   (dn_m_write),
    .dn_m_valid   (dn_m_valid),
    .dn_m_ready   (dn_m_ready),
    .dn_s_data    (dn_s_data),
    .dn_s_valid   (dn_s_valid),
    .dn_s_ready   (dn_s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  mv, mw;
    logic [31:0] a0, a1, a2;
    logic        dnr;
    logic        sv;
    logic [31:0] sd;
    logic [2:0]  sr;
    logic [2:0]  e_mr;
    logic        e_dv;
    logic [31:0] e_addr;
    logic        e_wr;
    logic [31:0] e_data;
    logic [2:0]  e_sv;
    logic        e_sr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input string nm, input logic [2:0] mv, input logic [2:0] mw,
    input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
    input logic dnr, input logic sv, input logic [31:0] sd, input logic [2:0] sr,
    input logic [2:0] e_mr, input logic e_dv, input logic [31:0] e_addr,
    input logic e_wr, input logic [31:0] e_data, input logic [2:0] e_sv, input logic e_sr);
    vec_t v;
    v.name = nm; v.mv = mv; v.mw = mw; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.dnr = dnr; v.sv = sv; v.sd = sd; v.sr = sr;
    v.e_mr = e_mr; v.e_dv = e_dv; v.e_addr = e_addr; v.e_wr = e_wr;
    v.e_data = e_data; v.e_sv = e_sv; v.e_sr = e_sr;
    return v;
  endfunction

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    up_m_valid   = v.mv;
    up_m_write   = v.mw;
    up_m_address = {v.a2, v.a1, v.a0};
    up_m_data    = {P2D, P1D, P0D};
    dn_m_ready   = v.dnr;
    dn_s_valid   = v.sv;
    dn_s_data    = v.sd;
    up_s_ready   = v.sr;
  endtask

  task automatic checkVector(input vec_t v);
    checkOutput({v.name, ".up_m_ready"}, 32'(up_m_ready), 32'(v.e_mr));
    checkOutput({v.name, ".dn_m_valid"}, 32'(dn_m_valid), 32'(v.e_dv));
    if (v.e_dv) begin
      checkOutput({v.name, ".dn_m_address"}, dn_m_address, v.e_addr);
      checkOutput({v.name, ".dn_m_write"}, 32'(dn_m_write), 32'(v.e_wr));
      checkOutput({v.name, ".dn_m_data"}, dn_m_data, v.e_data);
    end
    checkOutput({v.name, ".up_s_valid"}, 32'(up_s_valid), 32'(v.e_sv));
    checkOutput({v.name, ".dn_s_ready"}, 32'(dn_s_ready), 32'(v.e_sr));
    checkOutput({v.name, ".up_s_data"}, up_s_data, v.sd);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".up_m_ready"}, 32'(up_m_ready), 32'h0);
    checkOutput({tag, ".dn_m_valid"}, 32'(dn_m_valid), 32'h0);
    checkOutput({tag, ".dn_m_address"}, dn_m_address, 32'h0);
    checkOutput({tag, ".dn_m_data"}, dn_m_data, 32'h0);
    checkOutput({tag, ".dn_m_write"}, 32'(dn_m_write), 32'h0);
    checkOutput({tag, ".up_s_valid"}, 32'(up_s_valid), 32'h0);
    checkOutput({tag, ".dn_s_ready"}, 32'(dn_s_ready), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Round robin with all ports storing, then an idle cycle and a stray response.
    vecs.push_back(mk("rr0", 3'b111, 3'b111, 32'h1000, 32'h1010, 32'h1020, 1, 0, 0, 3'b000, 3'b001, 0, 0, 0, 0, 3'b000, 0));
    vecs.push_back(mk("rr1", 3'b111, 3'b111, 32'h1000, 32'h1010, 32'h1020, 1, 0, 0, 3'b000, 3'b010, 1, 32'h1000, 1, P0D, 3'b000, 0));
    vecs.push_back(mk("rr2", 3'b111, 3'b111, 32'h1000, 32'h1010, 32'h1020, 1, 0, 0, 3'b000, 3'b100, 1, 32'h1010, 1, P1D, 3'b000, 0));
    vecs.push_back(mk("rr3", 3'b111, 3'b111, 32'h1000, 32'h1010, 32'h1020, 1, 0, 0, 3'b000, 3'b001, 1, 32'h1020, 1, P2D, 3'b000, 0));
    vecs.push_back(mk("rr4", 3'b111, 3'b111, 32'h1000, 32'h1010, 32'h1020, 1, 0, 0, 3'b000, 3'b010, 1, 32'h1000, 1, P0D, 3'b000, 0));
    vecs.push_back(mk("rr5", 3'b111, 3'b111, 32'h1000, 32'h1010, 32'h1020, 1, 0, 0, 3'b000, 3'b100, 1, 32'h1010, 1, P1D, 3'b000, 0));
    vecs.push_back(mk("idle", 3'b000, 3'b000, 32'h1000, 32'h1010, 32'h1020, 1, 0, 0, 3'b000, 3'b000, 1, 32'h1020, 1, P2D, 3'b000, 0));
    vecs.push_back(mk("rsp_empty0", 3'b000, 3'b000, 0, 0, 0, 1, 1, 32'hDEAD, 3'b111, 3'b000, 0, 0, 0, 0, 3'b000, 0));
    // Downstream backpressure: load from port 1 held for three cycles.
    vecs.push_back(mk("bp0", 3'b010, 3'b000, 32'h40, 32'h100, 0, 0, 0, 0, 3'b000, 3'b010, 0, 0, 0, 0, 3'b000, 0));
    vecs.push_back(mk("bp1", 3'b001, 3'b001, 32'h40, 32'h100, 0, 0, 0, 0, 3'b000, 3'b000, 1, 32'h100, 0, P1D, 3'b000, 0));
    vecs.push_back(mk("bp2", 3'b001, 3'b001, 32'h40, 32'h100, 0, 0, 0, 0, 3'b000, 3'b000, 1, 32'h100, 0, P1D, 3'b000, 0));
    vecs.push_back(mk("bp3", 3'b001, 3'b001, 32'h40, 32'h100, 0, 0, 0, 0, 3'b000, 3'b000, 1, 32'h100, 0, P1D, 3'b000, 0));
    vecs.push_back(mk("bp4", 3'b001, 3'b001, 32'h40, 32'h100, 0, 1, 0, 0, 3'b000, 3'b001, 1, 32'h100, 0, P1D, 3'b000, 0));
    vecs.push_back(mk("bp5", 3'b000, 3'b000, 32'h40, 32'h100, 0, 1, 0, 0, 3'b000, 3'b000, 1, 32'h40, 1, P0D, 3'b000, 0));
    // Response backpressure from port 1, then the pop, then an empty FIFO.
    vecs.push_back(mk("rsp_hold", 3'b000, 3'b000, 0, 0, 0, 1, 1, 32'h1234, 3'b101, 3'b000, 0, 0, 0, 0, 3'b010, 0));
    vecs.push_back(mk("rsp_pop", 3'b000, 3'b000, 0, 0, 0, 1, 1, 32'h1234, 3'b111, 3'b000, 0, 0, 0, 0, 3'b010, 1));
    vecs.push_back(mk("rsp_empty1", 3'b000, 3'b000, 0, 0, 0, 1, 1, 32'h5678, 3'b111, 3'b000, 0, 0, 0, 0, 3'b000, 0));
    // In-order response routing.
    vecs.push_back(mk("rt0", 3'b001, 3'b000, 32'h10, 32'h20, 0, 1, 0, 0, 3'b000, 3'b001, 0, 0, 0, 0, 3'b000, 0));
    vecs.push_back(mk("rt1", 3'b010, 3'b000, 32'h10, 32'h20, 0, 1, 0, 0, 3'b000, 3'b010, 1, 32'h10, 0, P0D, 3'b000, 0));
    vecs.push_back(mk("rt2", 3'b000, 3'b000, 32'h10, 32'h20, 0, 1, 0, 0, 3'b000, 3'b000, 1, 32'h20, 0, P1D, 3'b000, 0));
    vecs.push_back(mk("rt3", 3'b000, 3'b000, 0, 0, 0, 1, 1, 32'hAAAA, 3'b111, 3'b000, 0, 0, 0, 0, 3'b001, 1));
    vecs.push_back(mk("rt4", 3'b000, 3'b000, 0, 0, 0, 1, 1, 32'hBBBB, 3'b111, 3'b000, 0, 0, 0, 0, 3'b010, 1));
    // Outstanding limit: third load stalls, store still passes, load follows the pop.
    vecs.push_back(mk("ol0", 3'b100, 3'b000, 0, 0, 32'h300, 1, 0, 0, 3'b000, 3'b100, 0, 0, 0, 0, 3'b000, 0));
    vecs.push_back(mk("ol1", 3'b001, 3'b000, 32'h310, 0, 0, 1, 0, 0, 3'b000, 3'b001, 1, 32'h300, 0, P2D, 3'b000, 0));
    vecs.push_back(mk("ol2", 3'b110, 3'b100, 0, 32'h320, 32'h330, 1, 0, 0, 3'b000, 3'b100, 1, 32'h310, 0, P0D, 3'b000, 0));
    vecs.push_back(mk("ol3", 3'b010, 3'b000, 0, 32'h320, 0, 1, 1, 32'hC0C0, 3'b111, 3'b000, 1, 32'h330, 1, P2D, 3'b100, 1));
    vecs.push_back(mk("ol4", 3'b010, 3'b000, 0, 32'h320, 0, 1, 0, 0, 3'b000, 3'b010, 0, 0, 0, 0, 3'b000, 0));
    vecs.push_back(mk("ol5", 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 3'b000, 3'b000, 1, 32'h320, 0, P1D, 3'b000, 0));
    // Park a store in the output register with two loads still outstanding.
    vecs.push_back(mk("park", 3'b100, 3'b100, 0, 0, 32'h340, 0, 0, 0, 3'b000, 3'b100, 0, 0, 0, 0, 3'b000, 0));

    rst_n = 1'b0;
    applyStimulus(mk("rst", 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    #1 checkAllZero("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1 checkVector(vecs[i]);
    end

    // Asynchronous reset in the middle of a cycle with work in flight.
    @(negedge clk);
    applyStimulus(mk("pre", 3'b000, 3'b000, 0, 0, 0, 0, 1, 32'h9999, 3'b111, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("pre_rst.dn_m_valid", 32'(dn_m_valid), 32'h1);
    checkOutput("pre_rst.dn_m_address", dn_m_address, 32'h340);
    checkOutput("pre_rst.up_s_valid", 32'(up_s_valid), 32'h1);
    checkOutput("pre_rst.dn_s_ready", 32'(dn_s_ready), 32'h1);
    #1 rst_n = 1'b0;
    #1 checkAllZero("mid_rst");

    @(negedge clk);
    applyStimulus(mk("post", 3'b111, 3'b111, 32'h1000, 32'h1010, 32'h1020, 1, 1, 32'h7777, 3'b111, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst.up_m_ready", 32'(up_m_ready), 32'h1);
    checkOutput("post_rst.dn_m_valid", 32'(dn_m_valid), 32'h0);
    checkOutput("post_rst.up_s_valid", 32'(up_s_valid), 32'h0);
    checkOutput("post_rst.dn_s_ready", 32'(dn_s_ready), 32'h0);
    @(negedge clk);
    #1;
    checkOutput("post_rst1.dn_m_valid", 32'(dn_m_valid), 32'h1);
    checkOutput("post_rst1.dn_m_address", dn_m_address, 32'h1000);
    checkOutput("post_rst1.up_m_ready", 32'(up_m_ready), 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
